// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column drive, row synchronization, per-scan
// key resolution and scan-level debounce of press and release.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_drive,
    output logic [3:0] key_c,
    output logic [3:0] key_r,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       multi_err
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [3:0]    row_meta, row_sync;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic [11:0]   acc;
    logic          sample, scan_end;
    logic [15:0]   scan_vec;
    logic [1:0]    n_low;
    logic [3:0]    hit_idx;
    logic          is_none, is_single, is_multi;
    logic [3:0]    hit_c, hit_r;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    cand;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    assign sample    = (dwell == DWELL_LAST);
    assign scan_end  = sample && (col_idx == 2'd3);
    assign col_drive = ~(4'b0001 << col_idx);

    // Columns 0-2 are latched into acc; column 3 is combined live at scan end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell   <= '0;
            col_idx <= '0;
            acc     <= '0;
        end else if (sample) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            case (col_idx)
                2'd0:    acc[3:0]  <= ~row_sync;
                2'd1:    acc[7:4]  <= ~row_sync;
                2'd2:    acc[11:8] <= ~row_sync;
                default: acc       <= '0;
            endcase
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    always_comb begin
        scan_vec = {~row_sync, acc};
        n_low    = '0;
        hit_idx  = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (scan_vec[i]) begin
                hit_idx = 4'(i);
                if (n_low != 2'd2) n_low = n_low + 2'd1;
            end
        end
    end

    assign is_none   = (n_low == 2'd0);
    assign is_single = (n_low == 2'd1);
    assign is_multi  = (n_low == 2'd2);
    assign hit_c     = ~(4'b0001 << hit_idx[3:2]);
    assign hit_r     = ~(4'b0001 << hit_idx[1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_c     <= '1;
            key_r     <= '1;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            multi_err <= scan_end && is_multi;
            if (scan_end) begin
                case (state)
                    IDLE: begin
                        if (is_single) begin
                            cand <= hit_idx;
                            cnt  <= CW'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                state     <= PRESSED;
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                key_code  <= hit_idx;
                                key_c     <= hit_c;
                                key_r     <= hit_r;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (is_single && hit_idx == cand) begin
                            if (cnt >= CNT_MAX - 1'b1) begin
                                cnt       <= CNT_MAX;
                                state     <= PRESSED;
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                key_code  <= hit_idx;
                                key_c     <= hit_c;
                                key_r     <= hit_r;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (is_none) begin
                            // The first empty scan already counts toward release.
                            if (DEBOUNCE_SCANS == 1) begin
                                state    <= IDLE;
                                cnt      <= '0;
                                key_down <= 1'b0;
                                key_c    <= '1;
                                key_r    <= '1;
                            end else begin
                                state <= RELEASE;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    RELEASE: begin
                        if (is_none) begin
                            if (cnt >= CNT_MAX - 1'b1) begin
                                state    <= IDLE;
                                cnt      <= '0;
                                key_down <= 1'b0;
                                key_c    <= '1;
                                key_r    <= '1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives row_in from
// col_drive, stimulus queues expected accepted keys, a monitor checks them.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_drive, key_c, key_r, key_code;
    logic       key_valid, key_down, multi_err;
    logic [15:0] keys;

    typedef struct packed {
        logic [3:0] code;
        logic [3:0] c;
        logic [3:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_valid = 0;
    int   n_multi = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_drive (col_drive),
        .key_c     (key_c),
        .key_r     (key_r),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .multi_err (multi_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int k = 0; k < 16; k++)
            if (keys[k] && !col_drive[k / 4]) row_in[k % 4] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every key_valid pops one expected key.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (key_valid) begin
                n_valid++;
                check("valid_one_cycle", prev_valid, 0);
                if (exp_q.size() == 0) begin
                    check("valid_unexpected_qsize", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("key_code", key_code, e.code);
                    check("key_c", key_c, e.c);
                    check("key_r", key_r, e.r);
                    check("key_down_at_valid", key_down, 1);
                end
            end
            if (multi_err) n_multi++;
            prev_valid = key_valid;
        end
    end

    task automatic align();
        logic [3:0] prev;
        prev = col_drive;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (col_drive == 4'b1110 && prev == 4'b0111) return;
            prev = col_drive;
        end
        check("align_timeout", col_drive, 4'b1110);
    endtask

    task automatic wait_valid(input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (key_valid) return;
        end
        check(name, key_valid, 1);
    endtask

    task automatic wait_released(input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (!key_down) return;
        end
        check(name, key_down, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_col;
        logic       hold_ok;
        int         nv0, nm0;

        reset = 1'b0;
        keys  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col_drive", col_drive, 4'b1110);
        check("rst_key_c", key_c, 4'hF);
        check("rst_key_r", key_r, 4'hF);
        check("rst_key_code", key_code, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_down", key_down, 0);
        check("rst_multi_err", multi_err, 0);

        // Idle scanning: column steps every 4 clocks.
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            exp_col = 4'b1111 ^ (4'b0001 << ((i / 4) % 4));
            check("idle_col_drive", col_drive, exp_col);
            @(posedge clk); #1;
        end
        check("idle_key_c", key_c, 4'hF);
        check("idle_key_down", key_down, 0);
        check("idle_multi_count", n_multi, 0);

        // Key 9 (col2,row1).
        align();
        keys = 16'h0001 << 9;
        exp_q.push_back('{code: 4'd9, c: 4'b1011, r: 4'b1101});
        wait_valid(51, "k9_valid_timeout");
        repeat (32) @(posedge clk);
        #1;
        check("k9_held_down", key_down, 1);
        align();
        keys = '0;
        wait_released(51, "k9_release_timeout");
        check("k9_rel_key_c", key_c, 4'hF);
        check("k9_rel_key_r", key_r, 4'hF);
        check("k9_rel_key_code", key_code, 9);

        // Key 15 for one scan only: must not be accepted.
        nv0 = n_valid;
        align();
        keys = 16'h0001 << 15;
        repeat (16) @(posedge clk);
        #1;
        keys = '0;
        repeat (48) @(posedge clk);
        #1;
        check("k15_no_valid", n_valid - nv0, 0);
        check("k15_key_c", key_c, 4'hF);
        check("k15_key_down", key_down, 0);

        // Keys 0 and 5 together for 4 scans.
        nv0 = n_valid;
        nm0 = n_multi;
        align();
        keys = (16'h0001 << 0) | (16'h0001 << 5);
        repeat (64) @(posedge clk);
        #1;
        keys = '0;
        repeat (8) @(posedge clk);
        #1;
        check("multi_pulses", n_multi - nm0, 4);
        check("multi_no_valid", n_valid - nv0, 0);
        check("multi_key_down", key_down, 0);

        // Key 12, one empty scan, then held again: release bounce.
        nv0 = n_valid;
        align();
        keys = 16'h0001 << 12;
        exp_q.push_back('{code: 4'd12, c: 4'b0111, r: 4'b1110});
        wait_valid(51, "k12_valid_timeout");
        hold_ok = key_down;
        align();
        hold_ok &= key_down;
        keys = '0;
        repeat (16) begin
            @(posedge clk); #1;
            hold_ok &= key_down;
        end
        keys = 16'h0001 << 12;
        repeat (48) begin
            @(posedge clk); #1;
            hold_ok &= key_down;
        end
        check("k12_down_throughout", hold_ok, 1);
        check("k12_single_valid", n_valid - nv0, 1);
        keys = '0;
        wait_released(67, "k12_release_timeout");

        // Key 3, then reset pulse while held.
        align();
        keys = 16'h0001 << 3;
        exp_q.push_back('{code: 4'd3, c: 4'b1110, r: 4'b0111});
        wait_valid(51, "k3_valid_timeout");
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("k3_rst_key_c", key_c, 4'hF);
        check("k3_rst_key_r", key_r, 4'hF);
        check("k3_rst_key_down", key_down, 0);
        check("k3_rst_key_code", key_code, 0);
        check("k3_rst_col_drive", col_drive, 4'b1110);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.push_back('{code: 4'd3, c: 4'b1110, r: 4'b0111});
        wait_valid(51, "k3_revalid_timeout");
        keys = '0;
        wait_released(67, "k3_release_timeout");
        repeat (4) @(posedge clk);
        #1;
        check("exp_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
